data_ram: RTL and testbench
===========================

DATA_RAM -- requirements
Module: data_ram

Interface
REQ-001 Parameter MEM_WORDS, default 1024, number of 32-bit words in the storage array (power of two).
REQ-002 Parameter SB_DEPTH, default 4, store-buffer entries (power of two, >=2).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 ce_in  input  1  access enable from CPU memory stage (ram_ce_out).
REQ-006 we_in  input  1  1 = store, 0 = load; valid only with ce_in=1.
REQ-007 addr_in  input  32  byte address; word index = addr_in[log2(MEM_WORDS)+1:2].
REQ-008 data_in  input  32  store data, byte-lane aligned.
REQ-009 sel_in  input  4  byte enables; sel_in[3] = data bits 31:24.
REQ-010 data_out  output  32  load data to CPU (ram_data_in).
REQ-011 sb_count_out  output  log2(SB_DEPTH)+1  current store-buffer occupancy.
REQ-012 sb_empty_out  output  1  high when sb_count_out = 0.

Function
REQ-013 Load (ce_in=1, we_in=0) SHALL return data_out combinationally in the same cycle, zero-wait, matching the CPU's single-cycle memory stage.
REQ-014 Load data SHALL be built per byte lane: youngest store-buffer entry with matching word index and set byte enable wins; otherwise array byte; all four lanes returned regardless of sel_in.
REQ-015 data_out SHALL be 0 when ce_in=0 or we_in=1.
REQ-016 Store (ce_in=1, we_in=1) SHALL be pushed into the store buffer at the clock edge as {word index, data_in, sel_in}; a store with sel_in=0 SHALL be ignored.
REQ-017 Store buffer is a FIFO with write pointer, read pointer, count; pointers wrap modulo SB_DEPTH.
REQ-018 Drain: each edge with count>0 and no store pushed this cycle, the oldest entry SHALL be written into the array, updating only its enabled bytes.
REQ-019 Store while full (count=SB_DEPTH) SHALL drain oldest and push new in the same edge; count unchanged; no entry lost, no stall signalled.
REQ-020 Store while not full SHALL push without draining; count increments by 1.
REQ-021 Two stores to the same word SHALL coexist in the buffer; drain order preserves program order so the array holds the youngest bytes.
REQ-022 Address bits above the word index SHALL be ignored (aliasing wrap); addr_in[1:0] SHALL be ignored.

Reset
REQ-023 rst low SHALL asynchronously clear pointers and count to 0; sb_empty_out=1, sb_count_out=0.
REQ-024 Buffered, undrained stores SHALL be discarded on reset mid-operation; the storage array SHALL NOT be reset.

Configuration
REQ-025 Macro DATA_RAM_STBUF_EN: when defined, store buffer, forwarding and drain per REQ-014..REQ-021.
REQ-026 When undefined, stores SHALL write the array directly at the edge with byte enables, loads read the array only, sb_count_out tied 0, sb_empty_out tied 1.

Structure
REQ-027 `RegBus width, MEM_WORDS and SB_DEPTH defaults, and the log2 widths SHALL live in the shared defines file alongside existing bus macros.
REQ-028 One sub-module, store_buffer: FIFO storage, pointers, count and per-lane forwarding lookup; data_ram holds the array and drain write port.

Verification
REQ-029 Reset, store 0xDEADBEEF sel=1111 @0x10, next-cycle load @0x10 -> data_out=0xDEADBEEF via forwarding, sb_count_out=1.
REQ-030 After REQ-029 scenario, one idle cycle -> sb_count_out=0; load @0x10 -> 0xDEADBEEF from array.
REQ-031 Store 0x11223344 sel=1111 @0x20 then 0x000000AA sel=0001 @0x20 back-to-back, load @0x20 -> 0x112233AA; after drain same.
REQ-032 Five consecutive stores 0x1..0x5 to words 0..4 with SB_DEPTH=4 -> count saturates at 4, word 0 drained to array on 5th edge, all five load back correctly.
REQ-033 Two stores buffered, assert rst low asynchronously mid-cycle -> count=0 immediately, loads return prior array contents.
REQ-034 Load @0x10 and @(0x10 + 4*MEM_WORDS) -> identical data (alias); ce_in=0 -> data_out=0.

Source files
------------

// File: rtl/data_ram_pkg.sv
// data_ram_pkg -- shared bus widths, size defaults and lane helper.
// Store buffer is built only when DATA_RAM_STBUF_EN is defined.
package data_ram_pkg;

    localparam int REG_BUS       = 32;
    localparam int SEL_W         = REG_BUS / 8;
    localparam int MEM_WORDS_DEF = 1024;
    localparam int SB_DEPTH_DEF  = 4;
    localparam int MEM_IDX_W     = $clog2(MEM_WORDS_DEF);
    localparam int SB_PTR_W      = $clog2(SB_DEPTH_DEF);
    localparam int SB_CNT_W      = SB_PTR_W + 1;

    typedef logic [REG_BUS-1:0] word_t;
    typedef logic [SEL_W-1:0]   sel_t;

    // Take each byte from over where sel is set, else from base.
    function automatic word_t lane_mux(
        input word_t base,
        input word_t over,
        input sel_t  sel
    );
        word_t r;
        r = base;
        for (int b = 0; b < SEL_W; b++) begin
            if (sel[b]) begin
                r[8*b +: 8] = over[8*b +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/data_ram_store_buffer.sv
// data_ram_store_buffer -- store FIFO with per-lane load forwarding.
// Compiled only when DATA_RAM_STBUF_EN is defined.
`ifdef DATA_RAM_STBUF_EN
module data_ram_store_buffer
    import data_ram_pkg::*;
#(
    parameter int SB_DEPTH = SB_DEPTH_DEF,
    parameter int IDX_W    = MEM_IDX_W,
    parameter int PTR_W    = SB_PTR_W,
    parameter int CNT_W    = SB_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [IDX_W-1:0] push_idx,
    input  word_t            push_data,
    input  sel_t             push_sel,
    input  logic [IDX_W-1:0] lookup_idx,
    output word_t            fwd_data,
    output sel_t             fwd_hit,
    output logic             drain_valid,
    output logic [IDX_W-1:0] drain_idx,
    output word_t            drain_data,
    output sel_t             drain_sel,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    logic [IDX_W-1:0] ent_idx  [SB_DEPTH];
    word_t            ent_data [SB_DEPTH];
    sel_t             ent_sel  [SB_DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             drain;
    logic [PTR_W-1:0] k;

    assign full  = (count == CNT_W'(SB_DEPTH));
    assign empty = (count == '0);
    // Retire oldest on idle edges, or alongside a push when full.
    assign drain = !empty && (!push || full);

    assign drain_valid = drain;
    assign drain_idx   = ent_idx[rd_ptr];
    assign drain_data  = ent_data[rd_ptr];
    assign drain_sel   = ent_sel[rd_ptr];

    // Entry payload; the slot freed by a full-drain is reused at once.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_idx[wr_ptr]  <= push_idx;
            ent_data[wr_ptr] <= push_data;
            ent_sel[wr_ptr]  <= push_sel;
        end
    end

    // Pointers and occupancy; reset drops anything not yet drained.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (drain) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push, drain})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Walk oldest to youngest so the youngest matching byte wins.
    always_comb begin
        fwd_data = '0;
        fwd_hit  = '0;
        k        = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            k = rd_ptr + PTR_W'(i);
            if ((CNT_W'(i) < count) && (ent_idx[k] == lookup_idx)) begin
                for (int b = 0; b < SEL_W; b++) begin
                    if (ent_sel[k][b]) begin
                        fwd_hit[b]          = 1'b1;
                        fwd_data[8*b +: 8]  = ent_data[k][8*b +: 8];
                    end
                end
            end
        end
    end

endmodule
`endif

// File: rtl/data_ram.sv
// data_ram -- zero-wait data memory for the CPU memory stage.
// Define DATA_RAM_STBUF_EN to place a store buffer in front of the array.
module data_ram
    import data_ram_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEF,
    parameter int SB_DEPTH  = SB_DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ce_in,
    input  logic                      we_in,
    input  logic [REG_BUS-1:0]        addr_in,
    input  logic [REG_BUS-1:0]        data_in,
    input  logic [SEL_W-1:0]          sel_in,
    output logic [REG_BUS-1:0]        data_out,
    output logic [$clog2(SB_DEPTH):0] sb_count_out,
    output logic                      sb_empty_out
);

    localparam int IW = $clog2(MEM_WORDS);
    localparam int PW = $clog2(SB_DEPTH);
    localparam int CW = PW + 1;

    word_t          mem [MEM_WORDS];
    logic [IW-1:0]  idx;
    logic           load;
    logic           store;
    word_t          arr_rd;

    assign idx    = addr_in[IW+1:2];
    assign load   = ce_in && !we_in;
    assign store  = ce_in && we_in && (sel_in != '0);
    assign arr_rd = mem[idx];

`ifdef DATA_RAM_STBUF_EN

    word_t         fwd_data;
    sel_t          fwd_hit;
    logic          drain_valid;
    logic [IW-1:0] drain_idx;
    word_t         drain_data;
    sel_t          drain_sel;
    logic          unused_addr;

    assign unused_addr = ^{addr_in[REG_BUS-1:IW+2], addr_in[1:0]};

    data_ram_store_buffer #(
        .SB_DEPTH (SB_DEPTH),
        .IDX_W    (IW),
        .PTR_W    (PW),
        .CNT_W    (CW)
    ) u_store_buffer (
        .clk         (clk),
        .rst         (rst),
        .push        (store),
        .push_idx    (idx),
        .push_data   (data_in),
        .push_sel    (sel_in),
        .lookup_idx  (idx),
        .fwd_data    (fwd_data),
        .fwd_hit     (fwd_hit),
        .drain_valid (drain_valid),
        .drain_idx   (drain_idx),
        .drain_data  (drain_data),
        .drain_sel   (drain_sel),
        .count       (sb_count_out),
        .empty       (sb_empty_out)
    );

    // Drain port: oldest buffered store lands in the array.
    always_ff @(posedge clk) begin
        if (drain_valid) begin
            mem[drain_idx] <= lane_mux(mem[drain_idx], drain_data, drain_sel);
        end
    end

    // Load data: buffered bytes override array bytes lane by lane.
    always_comb begin
        data_out = '0;
        if (load) begin
            data_out = lane_mux(arr_rd, fwd_data, fwd_hit);
        end
    end

`else

    logic unused_bits;

    assign unused_bits  = ^{rst, addr_in[REG_BUS-1:IW+2], addr_in[1:0]};
    assign sb_count_out = '0;
    assign sb_empty_out = 1'b1;

    // Direct write port: stores update enabled bytes at the edge.
    always_ff @(posedge clk) begin
        if (store) begin
            mem[idx] <= lane_mux(mem[idx], data_in, sel_in);
        end
    end

    // Load data straight from the array.
    always_comb begin
        data_out = '0;
        if (load) begin
            data_out = arr_rd;
        end
    end

`endif

endmodule

// File: tb/tb_data_ram.sv
// tb_data_ram -- directed self-checking bench for data_ram.
// Expected occupancies follow DATA_RAM_STBUF_EN.
module tb_data_ram;

`ifdef DATA_RAM_STBUF_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        ce_in;
    logic        we_in;
    logic [31:0] addr_in;
    logic [31:0] data_in;
    logic [3:0]  sel_in;
    logic [31:0] data_out;
    logic [2:0]  sb_count_out;
    logic        sb_empty_out;

    int total;
    int passed;
    int failed;

    data_ram #(
        .MEM_WORDS (1024),
        .SB_DEPTH  (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ce_in        (ce_in),
        .we_in        (we_in),
        .addr_in      (addr_in),
        .data_in      (data_in),
        .sel_in       (sel_in),
        .data_out     (data_out),
        .sb_count_out (sb_count_out),
        .sb_empty_out (sb_empty_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic ce, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        ce_in   = ce;
        we_in   = we;
        addr_in = a;
        data_in = d;
        sel_in  = s;
        #1;
    endtask

    function automatic logic [31:0] cnt(input int n);
        return SB ? 32'(n) : 32'd0;
    endfunction

    initial begin
        total   = 0;
        passed  = 0;
        failed  = 0;
        rst     = 1'b0;
        ce_in   = 1'b0;
        we_in   = 1'b0;
        addr_in = '0;
        data_in = '0;
        sel_in  = '0;

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_count", 32'(sb_count_out), 32'd0);
        chk("rst_empty", 32'(sb_empty_out), 32'd1);
        chk("rst_dout", data_out, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // store then forwarded load, then load from array
        drive(1, 1, 32'h10, 32'hDEADBEEF, 4'hF);
        chk("st_dout_zero", data_out, 32'd0);
        drive(1, 0, 32'h10, 32'h0, 4'h0);
        chk("fwd_ld", data_out, 32'hDEADBEEF);
        chk("fwd_count", 32'(sb_count_out), cnt(1));
        chk("fwd_empty", 32'(sb_empty_out), SB ? 32'd0 : 32'd1);
        drive(1, 0, 32'h10, 32'h0, 4'h0);
        chk("arr_ld", data_out, 32'hDEADBEEF);
        chk("arr_count", 32'(sb_count_out), 32'd0);
        chk("arr_empty", 32'(sb_empty_out), 32'd1);

        // two stores to one word, partial overlay
        drive(1, 1, 32'h20, 32'h11223344, 4'hF);
        drive(1, 1, 32'h20, 32'h000000AA, 4'h1);
        chk("merge_cnt1", 32'(sb_count_out), cnt(1));
        drive(1, 0, 32'h20, 32'h0, 4'h0);
        chk("merge_ld2", data_out, 32'h112233AA);
        chk("merge_cnt2", 32'(sb_count_out), cnt(2));
        drive(1, 0, 32'h20, 32'h0, 4'h0);
        chk("merge_ld1", data_out, 32'h112233AA);
        chk("merge_cntd", 32'(sb_count_out), cnt(1));
        drive(1, 0, 32'h23, 32'h0, 4'h0);
        chk("merge_ld0", data_out, 32'h112233AA);
        chk("merge_cnt0", 32'(sb_count_out), 32'd0);

        // five stores into a 4-deep buffer
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 32'(4 * i), 32'(i + 1), 4'hF);
            chk($sformatf("fill_cnt%0d", i), 32'(sb_count_out), cnt(i));
        end
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 32'(4 * i), 32'h0, 4'h0);
            chk($sformatf("fill_ld%0d", i), data_out, 32'(i + 1));
            chk($sformatf("fill_lc%0d", i), 32'(sb_count_out), cnt(4 - i));
        end

        // seed array, then discard buffered stores with async reset
        drive(1, 1, 32'h40, 32'hCAFEF00D, 4'hF);
        drive(1, 1, 32'h44, 32'h0BADC0DE, 4'hF);
        drive(1, 0, 32'h40, 32'h0, 4'h0);
        chk("seed_ld40", data_out, 32'hCAFEF00D);
        drive(1, 0, 32'h44, 32'h0, 4'h0);
        chk("seed_ld44", data_out, 32'h0BADC0DE);
        drive(0, 0, 32'h0, 32'h0, 4'h0);
        drive(1, 1, 32'h40, 32'h12345678, 4'hF);
        drive(1, 1, 32'h44, 32'h9ABCDEF0, 4'hF);
        drive(0, 0, 32'h0, 32'h0, 4'h0);
        chk("pre_rst_cnt", 32'(sb_count_out), cnt(2));
        #1;
        rst = 1'b0;
        #1;
        chk("async_cnt", 32'(sb_count_out), 32'd0);
        chk("async_empty", 32'(sb_empty_out), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        drive(1, 0, 32'h40, 32'h0, 4'h0);
        chk("post_rst40", data_out, SB ? 32'hCAFEF00D : 32'h12345678);
        drive(1, 0, 32'h44, 32'h0, 4'h0);
        chk("post_rst44", data_out, SB ? 32'h0BADC0DE : 32'h9ABCDEF0);

        // aliasing, disabled access, empty byte-enable store
        drive(1, 0, 32'h10, 32'h0, 4'h0);
        chk("alias_base", data_out, 32'd5);
        drive(1, 0, 32'h10 + 32'd4096, 32'h0, 4'h0);
        chk("alias_wrap", data_out, 32'd5);
        drive(1, 0, 32'h8000_0010, 32'h0, 4'h0);
        chk("alias_hi", data_out, 32'd5);
        drive(0, 0, 32'h10, 32'h0, 4'h0);
        chk("ce_off", data_out, 32'd0);
        drive(1, 1, 32'h10, 32'hFFFFFFFF, 4'h0);
        chk("sel0_dout", data_out, 32'd0);
        drive(1, 0, 32'h10, 32'h0, 4'h0);
        chk("sel0_cnt", 32'(sb_count_out), 32'd0);
        chk("sel0_ld", data_out, 32'd5);

        // byte-lane partial store to aliased address
        drive(1, 1, 32'h1012, 32'hA0B0C0D0, 4'h6);
        drive(1, 0, 32'h10, 32'h0, 4'h0);
        chk("lane_ld", data_out, 32'h00B0C005);
        chk("lane_cnt", 32'(sb_count_out), cnt(1));
        drive(1, 0, 32'h10, 32'h0, 4'h0);
        chk("lane_arr", data_out, 32'h00B0C005);

        drive(0, 0, 32'h0, 32'h0, 4'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
